// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select lines of an 8:1 data mux over a latched
// channel mask, waits a settle interval per select change, captures the mux
// output and offers it on a valid/ready stream tagged with its channel number.
// Single-pass or continuous (wrap-around) scanning; stop ends at pass boundary.
// Optional build macro MUX_SCAN_PARITY_EN adds o_out_parity (XOR of the sample).
module mux_scan_sequencer #(
   parameter int DATA_W     = 8,
   parameter int NUM_CH     = 8,
   parameter int SEL_W      = 3,
   parameter int SETTLE_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_continuous,
   input  logic              i_stop,
   input  logic [NUM_CH-1:0] i_ch_mask,
   output logic [SEL_W-1:0]  o_select,
   input  logic [DATA_W-1:0] i_mux_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [SEL_W-1:0]  o_out_ch,
   output logic              o_out_last,
`ifdef MUX_SCAN_PARITY_EN
   output logic              o_out_parity,
`endif
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYC);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t              r_state, w_state_nxt;
   logic [NUM_CH-1:0]   r_mask, w_mask_nxt;
   logic                r_cont, w_cont_nxt;
   logic                r_stop_pend, w_stop_pend_nxt;
   logic [3:0]          r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0]    r_sel, w_sel_nxt;
   logic                r_valid, w_valid_nxt;
   logic [DATA_W-1:0]   r_data, w_data_nxt;
   logic [SEL_W-1:0]    r_ch, w_ch_nxt;
   logic                r_last, w_last_nxt;
   logic                r_done, w_done_nxt;
`ifdef MUX_SCAN_PARITY_EN
   logic                r_parity, w_parity_nxt;
`endif

   logic                w_has_next;
   logic [SEL_W-1:0]    w_next_ch;

   // Lowest set bit of a channel mask (0 when the mask is empty)
   function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
      f_lowest = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) f_lowest = SEL_W'(i);
   endfunction

   // Priority search for the next enabled channel strictly above the current select
   always_comb begin
      w_has_next = 1'b0;
      w_next_ch  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_sel))) begin
            w_has_next = 1'b1;
            w_next_ch  = SEL_W'(i);
         end
      end
   end

   // Next-state and next-register logic for the scan FSM
   always_comb begin
      w_state_nxt     = r_state;
      w_mask_nxt      = r_mask;
      w_cont_nxt      = r_cont;
      w_stop_pend_nxt = r_stop_pend;
      w_cnt_nxt       = r_cnt;
      w_sel_nxt       = r_sel;
      w_valid_nxt     = r_valid;
      w_data_nxt      = r_data;
      w_ch_nxt        = r_ch;
      w_last_nxt      = r_last;
      w_done_nxt      = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      w_parity_nxt    = r_parity;
`endif
      case (r_state)
         IDLE: begin
            // start wins over a coincident stop; an empty mask is ignored
            if (i_start && (|i_ch_mask)) begin
               w_mask_nxt      = i_ch_mask;
               w_cont_nxt      = i_continuous;
               w_stop_pend_nxt = 1'b0;
               w_sel_nxt       = f_lowest(i_ch_mask);
               w_cnt_nxt       = LP_SETTLE;
               w_state_nxt     = SETTLE;
            end
         end
         SETTLE: begin
            w_stop_pend_nxt = r_stop_pend | i_stop;
            w_cnt_nxt       = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_cnt_nxt   = 4'd0;
               w_data_nxt  = i_mux_data;
               w_ch_nxt    = r_sel;
               w_last_nxt  = ~w_has_next;
               w_valid_nxt = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
               w_parity_nxt = ^i_mux_data;
`endif
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            w_stop_pend_nxt = r_stop_pend | i_stop;
            if (r_valid && i_out_ready) begin
               w_valid_nxt = 1'b0;
               if (w_has_next) begin
                  w_sel_nxt   = w_next_ch;
                  w_cnt_nxt   = LP_SETTLE;
                  w_state_nxt = SETTLE;
               end else if (r_cont && !(r_stop_pend || i_stop)) begin
                  // wrap: the lowest channel gets a full settle even if it equals select
                  w_sel_nxt   = f_lowest(r_mask);
                  w_cnt_nxt   = LP_SETTLE;
                  w_state_nxt = SETTLE;
               end else begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-high reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_mask      <= '0;
         r_cont      <= 1'b0;
         r_stop_pend <= 1'b0;
         r_cnt       <= '0;
         r_sel       <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_ch        <= '0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_mask      <= w_mask_nxt;
         r_cont      <= w_cont_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sel       <= w_sel_nxt;
         r_valid     <= w_valid_nxt;
         r_data      <= w_data_nxt;
         r_ch        <= w_ch_nxt;
         r_last      <= w_last_nxt;
         r_done      <= w_done_nxt;
`ifdef MUX_SCAN_PARITY_EN
         r_parity    <= w_parity_nxt;
`endif
      end
   end

   assign o_select    = r_sel;
   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_out_ch    = r_ch;
   assign o_out_last  = r_last;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = r_done;
`ifdef MUX_SCAN_PARITY_EN
   assign o_out_parity = r_parity;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: table of single-pass scans plus hand-written
// sequences for backpressure, continuous+stop, busy start, empty mask, reset.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, cont, stop, ready;
   logic [7:0] mask;
   logic [2:0] sel;
   logic [7:0] mux_data;
   logic       valid, last, busy, done;
   logic [7:0] odata;
   logic [2:0] och;
   logic       ovr_en;
   logic [7:0] ovr;
`ifdef MUX_SCAN_PARITY_EN
   logic       parity;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Bench mux: 100 + 10*select unless overridden
   assign mux_data = ovr_en ? ovr : 8'(100 + 10 * int'(sel));

   mux_scan_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_continuous(cont),
      .i_stop(stop), .i_ch_mask(mask), .o_select(sel), .i_mux_data(mux_data),
      .o_out_valid(valid), .i_out_ready(ready), .o_out_data(odata),
      .o_out_ch(och), .o_out_last(last),
`ifdef MUX_SCAN_PARITY_EN
      .o_out_parity(parity),
`endif
      .o_busy(busy), .o_done(done)
   );

   typedef struct {
      logic [7:0]  mask;
      int          n;
      logic [23:0] ch;
      logic [63:0] dat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] m, input logic c);
      @(negedge clk);
      start = 1'b1; mask = m; cont = c;
      @(negedge clk);
      start = 1'b0; mask = 8'h00; cont = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!valid && cyc < 50);
      chk("valid_seen", {31'd0, valid}, 32'd1);
   endtask

   task automatic expect_sample(input logic [2:0] c, input logic [7:0] d, input logic l);
      chk($sformatf("out_ch@%0d", c), {29'd0, och}, {29'd0, c});
      chk($sformatf("out_data@%0d", c), {24'd0, odata}, {24'd0, d});
      chk($sformatf("out_last@%0d", c), {31'd0, last}, {31'd0, l});
      chk($sformatf("select@%0d", c), {29'd0, sel}, {29'd0, c});
      chk($sformatf("no_done@%0d", c), {31'd0, done}, 32'd0);
   endtask

   // Expect samples k0..n-1 of a pass, then the done pulse
   task automatic run_pass(input logic [23:0] chs, input logic [63:0] dat,
                           input int n, input int k0, input bit rate);
      int cyc;
      for (int k = k0; k < n; k++) begin
         wait_valid(cyc);
         if (rate) chk($sformatf("spacing%0d", k), cyc, (k == 0) ? 2 : 3);
         expect_sample(chs[3*k +: 3], dat[8*k +: 8], k == n - 1);
      end
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_clear", {31'd0, done}, 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_select"}, {29'd0, sel}, 32'd0);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_data"}, {24'd0, odata}, 32'd0);
      chk({tag, "_ch"}, {29'd0, och}, 32'd0);
      chk({tag, "_last"}, {31'd0, last}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int cyc;
      int seen;
      rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; ready = 1'b1;
      mask = 8'h00; ovr_en = 1'b0; ovr = 8'h00;

      vecs[0] = '{mask: 8'hA5, n: 4, ch: {12'd0, 3'd7, 3'd5, 3'd2, 3'd0},
                  dat: {32'd0, 8'd170, 8'd150, 8'd120, 8'd100}};
      vecs[1] = '{mask: 8'h10, n: 1, ch: {21'd0, 3'd4}, dat: {56'd0, 8'd140}};
      vecs[2] = '{mask: 8'h80, n: 1, ch: {21'd0, 3'd7}, dat: {56'd0, 8'd170}};
      vecs[3] = '{mask: 8'h01, n: 1, ch: {21'd0, 3'd0}, dat: {56'd0, 8'd100}};
      vecs[4] = '{mask: 8'h42, n: 2, ch: {18'd0, 3'd6, 3'd1},
                  dat: {48'd0, 8'd160, 8'd110}};
      vecs[5] = '{mask: 8'hFF, n: 8,
                  ch: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                  dat: {8'd170, 8'd160, 8'd150, 8'd140, 8'd130, 8'd120, 8'd110, 8'd100}};

      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst = 1'b0;

      // Single-pass scans with out_ready held high: latency, rate, data, last, done
      foreach (vecs[i]) begin
         do_start(vecs[i].mask, 1'b0);
         run_pass(vecs[i].ch, vecs[i].dat, vecs[i].n, 0, 1'b1);
      end

      // Backpressure while ch2 is presented
      do_start(8'hA5, 1'b0);
      wait_valid(cyc);
      expect_sample(3'd0, 8'd100, 1'b0);
      @(negedge clk);
      ready = 1'b0;
      wait_valid(cyc);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid%0d", i), {31'd0, valid}, 32'd1);
         expect_sample(3'd2, 8'd120, 1'b0);
         @(negedge clk);
      end
      expect_sample(3'd2, 8'd120, 1'b0);
      ready = 1'b1;
      run_pass({12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, {32'd0, 8'd170, 8'd150, 8'd120, 8'd100},
               4, 2, 1'b0);

      // Continuous with stop during the second pass's ch0 sample
      do_start(8'h81, 1'b1);
      wait_valid(cyc);
      expect_sample(3'd0, 8'd100, 1'b0);
      wait_valid(cyc);
      expect_sample(3'd7, 8'd170, 1'b1);
      wait_valid(cyc);
      chk("wrap_spacing", cyc, 3);
      expect_sample(3'd0, 8'd100, 1'b0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      run_pass({12'd0, 3'd7, 3'd0, 3'd7, 3'd0}, {32'd0, 8'd170, 8'd100, 8'd170, 8'd100},
               4, 3, 1'b0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid || busy) seen++;
      end
      chk("no_third_pass", seen, 0);

      // Start with an empty mask is ignored
      do_start(8'h00, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("empty_busy%0d", i), {31'd0, busy}, 32'd0);
         chk($sformatf("empty_done%0d", i), {31'd0, done}, 32'd0);
         @(negedge clk);
      end

      // Start while busy (with different mask/continuous) has no effect
      do_start(8'hA5, 1'b0);
      wait_valid(cyc);
      expect_sample(3'd0, 8'd100, 1'b0);
      start = 1'b1; mask = 8'h10; cont = 1'b1;
      @(negedge clk);
      start = 1'b0; mask = 8'h00; cont = 1'b0;
      run_pass({12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, {32'd0, 8'd170, 8'd150, 8'd120, 8'd100},
               4, 1, 1'b0);
      chk("busy_start_idle", {31'd0, busy}, 32'd0);

      // Reset during the settle of ch5
      do_start(8'hA5, 1'b0);
      wait_valid(cyc);
      expect_sample(3'd0, 8'd100, 1'b0);
      wait_valid(cyc);
      expect_sample(3'd2, 8'd120, 1'b0);
      @(negedge clk);
      chk("pre_rst_sel", {29'd0, sel}, 32'd5);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("midrst");
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_nodone", {31'd0, done}, 32'd0);
      chk("midrst_novalid", {31'd0, valid}, 32'd0);
      do_start(8'hA5, 1'b0);
      run_pass({12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, {32'd0, 8'd170, 8'd150, 8'd120, 8'd100},
               4, 0, 1'b1);

`ifdef MUX_SCAN_PARITY_EN
      // Parity of the captured sample
      ovr_en = 1'b1;
      ovr = 8'h07;
      do_start(8'h01, 1'b0);
      wait_valid(cyc);
      chk("par_data07", {24'd0, odata}, 32'h07);
      chk("parity07", {31'd0, parity}, 32'd1);
      repeat (2) @(negedge clk);
      ovr = 8'h03;
      do_start(8'h01, 1'b0);
      wait_valid(cyc);
      chk("par_data03", {24'd0, odata}, 32'h03);
      chk("parity03", {31'd0, parity}, 32'd0);
      repeat (2) @(negedge clk);
      ovr_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
